// File: rtl/step_sequencer.sv
// Pattern step sequencer: plays up to STEPS {note, gate} entries against a
// tick timebase, driving the sound processor's tone select and envelope hold.
module step_sequencer #(
    parameter int STEPS      = 8,
    parameter int FREQ_BITS  = 4,
    parameter int TEMPO_BITS = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic                     run,
    input  logic [TEMPO_BITS-1:0]    tempo,
    input  logic [$clog2(STEPS)-1:0] last_step,
    input  logic                     wr_en,
    input  logic [$clog2(STEPS)-1:0] wr_addr,
    input  logic [FREQ_BITS-1:0]     wr_note,
    input  logic [1:0]               wr_gate,
    output logic [FREQ_BITS-1:0]     tone_freq_bin,
    output logic                     hold,
    output logic [$clog2(STEPS)-1:0] step_idx,
    output logic                     step_strobe,
    output logic                     playing
);

    localparam int AW = $clog2(STEPS);

    typedef enum logic {
        IDLE,
        PLAY
    } state_t;

    state_t                state;
    logic [FREQ_BITS-1:0]  note_mem [STEPS];
    logic [1:0]            gate_mem [STEPS];
    logic [TEMPO_BITS-1:0] cnt;
    logic [TEMPO_BITS-1:0] cnt_inc;
    logic [TEMPO_BITS-1:0] t_lat;
    logic [TEMPO_BITS-1:0] g_thr;

    logic [AW-1:0]         ld_idx;
    logic [FREQ_BITS-1:0]  ld_note;
    logic [1:0]            ld_gate;
    logic [TEMPO_BITS-1:0] tempo_eff;
    logic [TEMPO_BITS-1:0] quarter;
    logic [TEMPO_BITS-1:0] half;
    logic [TEMPO_BITS-1:0] ld_thr;
    logic                  do_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STEPS; i++) begin
                note_mem[i] <= '0;
                gate_mem[i] <= '0;
            end
        end else if (wr_en) begin
            note_mem[wr_addr] <= wr_note;
            gate_mem[wr_addr] <= wr_gate;
        end
    end

    // Write-through so an edit landing on the loading edge is what plays.
    always_comb begin
        ld_idx = '0;
        if (state == PLAY && step_idx < last_step)
            ld_idx = step_idx + AW'(1);
        ld_note = note_mem[ld_idx];
        ld_gate = gate_mem[ld_idx];
        if (wr_en && wr_addr == ld_idx) begin
            ld_note = wr_note;
            ld_gate = wr_gate;
        end
    end

    always_comb begin
        tempo_eff = (tempo == '0) ? TEMPO_BITS'(1) : tempo;
        quarter   = tempo_eff >> 2;
        half      = tempo_eff >> 1;
        ld_thr    = '0;
        unique case (ld_gate)
            2'b00: ld_thr = '0;
            2'b01: ld_thr = (quarter == '0) ? TEMPO_BITS'(1) : quarter;
            2'b10: ld_thr = (half == '0) ? TEMPO_BITS'(1) : half;
            2'b11: ld_thr = tempo_eff;
        endcase
    end

    assign cnt_inc = cnt + TEMPO_BITS'(1);
    assign do_load = run && tick &&
                     (state == IDLE || cnt == t_lat - TEMPO_BITS'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            tone_freq_bin <= '0;
            hold          <= 1'b0;
            step_idx      <= '0;
            step_strobe   <= 1'b0;
            playing       <= 1'b0;
            cnt           <= '0;
            t_lat         <= '0;
            g_thr         <= '0;
        end else begin
            step_strobe <= 1'b0;
            if (state == PLAY && !run) begin
                state    <= IDLE;
                hold     <= 1'b0;
                playing  <= 1'b0;
                step_idx <= '0;
                cnt      <= '0;
            end else if (do_load) begin
                state         <= PLAY;
                playing       <= 1'b1;
                step_idx      <= ld_idx;
                tone_freq_bin <= ld_note;
                t_lat         <= tempo_eff;
                g_thr         <= ld_thr;
                hold          <= (ld_gate != 2'b00);
                step_strobe   <= 1'b1;
                cnt           <= '0;
            end else if (state == PLAY && tick) begin
                cnt <= cnt_inc;
                if (cnt_inc == g_thr && g_thr < t_lat)
                    hold <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: playback, gating, stop, live edit,
// tempo and last_step boundaries, asynchronous reset.
module tb_step_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        run = 1'b0;
    logic [15:0] tempo = '0;
    logic [2:0]  last_step = '0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [3:0]  wr_note = '0;
    logic [1:0]  wr_gate = '0;
    logic [3:0]  tone_freq_bin;
    logic        hold;
    logic [2:0]  step_idx;
    logic        step_strobe;
    logic        playing;

    int n_chk  = 0;
    int n_pass = 0;

    step_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .run          (run),
        .tempo        (tempo),
        .last_step    (last_step),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_note      (wr_note),
        .wr_gate      (wr_gate),
        .tone_freq_bin(tone_freq_bin),
        .hold         (hold),
        .step_idx     (step_idx),
        .step_strobe  (step_strobe),
        .playing      (playing)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    endtask

    task automatic chk_out(input string tag, input int idx, input int note,
                           input int h, input int stb, input int ply);
        chk({tag, ".idx"}, 32'(step_idx), 32'(idx));
        chk({tag, ".note"}, 32'(tone_freq_bin), 32'(note));
        chk({tag, ".hold"}, 32'(hold), 32'(h));
        chk({tag, ".strobe"}, 32'(step_strobe), 32'(stb));
        chk({tag, ".playing"}, 32'(playing), 32'(ply));
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            @(negedge clk);
        end
        tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] n,
                      input logic [1:0] g);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_note = n;
        wr_gate = g;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        chk_out("rst0", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        wr(0, 1, 2'b11);
        wr(1, 2, 2'b10);
        wr(2, 3, 2'b01);
        wr(3, 4, 2'b00);
        last_step = 3;
        tempo     = 8;
        run       = 1'b1;
        idle(3);
        chk("run_no_tick", 32'(playing), 0);

        ticks(1);
        chk_out("s0", 0, 1, 1, 1, 1);
        idle(1);
        chk("s0_strobe_fall", 32'(step_strobe), 0);
        for (int k = 1; k < 8; k++) begin
            ticks(1);
            chk("s0_hold", 32'(hold), 1);
        end
        ticks(1);
        chk_out("s1_tie", 1, 2, 1, 1, 1);
        ticks(3);
        chk("s1_t3", 32'(hold), 1);
        ticks(1);
        chk("s1_t4", 32'(hold), 0);
        ticks(4);
        chk_out("s2", 2, 3, 1, 1, 1);
        ticks(1);
        chk("s2_t1", 32'(hold), 1);
        ticks(1);
        chk("s2_t2", 32'(hold), 0);
        ticks(6);
        chk_out("s3_rest", 3, 4, 0, 1, 1);
        ticks(7);
        chk("s3_end_hold", 32'(hold), 0);
        ticks(1);
        chk_out("wrap", 0, 1, 1, 1, 1);

        ticks(8);
        ticks(3);
        chk("pre_stop_idx", 32'(step_idx), 1);
        run = 1'b0;
        idle(1);
        chk_out("stop", 0, 2, 0, 0, 0);
        ticks(4);
        chk_out("stopped", 0, 2, 0, 0, 0);

        run = 1'b1;
        ticks(1);
        ticks(8);
        ticks(7);
        tick    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 2;
        wr_note = 9;
        wr_gate = 2'b10;
        @(negedge clk);
        tick  = 1'b0;
        wr_en = 1'b0;
        chk_out("edit", 2, 9, 1, 1, 1);
        ticks(3);
        chk("edit_t3", 32'(hold), 1);
        ticks(1);
        chk("edit_t4", 32'(hold), 0);
        ticks(3);
        run  = 1'b0;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        chk_out("stop_tick", 0, 9, 0, 0, 0);

        wr(0, 5, 2'b01);
        wr(1, 6, 2'b01);
        wr(2, 7, 2'b01);
        wr(3, 8, 2'b01);
        tempo = 0;
        run   = 1'b1;
        ticks(1);
        chk_out("t0_s0", 0, 5, 1, 1, 1);
        for (int k = 1; k < 6; k++) begin
            ticks(1);
            chk_out("t0", k % 4, 5 + k % 4, 1, 1, 1);
        end
        idle(1);
        chk("t0_idle_hold", 32'(hold), 1);
        chk("t0_idle_strobe", 32'(step_strobe), 0);
        run = 1'b0;
        idle(1);

        tempo = 2;
        run   = 1'b1;
        ticks(1);
        ticks(6);
        chk("low_s3", 32'(step_idx), 3);
        last_step = 1;
        ticks(1);
        chk("low_s3_mid", 32'(step_idx), 3);
        ticks(1);
        chk_out("low_wrap", 0, 5, 1, 1, 1);
        ticks(2);
        chk("low_s1", 32'(step_idx), 1);
        ticks(2);
        chk("low_wrap1", 32'(step_idx), 0);
        ticks(2);
        chk("low_s1b", 32'(step_idx), 1);

        rst = 1'b1;
        #1;
        chk_out("arst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        chk("post_rst_play", 32'(playing), 0);
        chk("post_rst_hold", 32'(hold), 0);
        ticks(1);
        chk_out("post_rst_mem", 0, 0, 0, 1, 1);
        run = 1'b0;
        idle(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
